// File: rtl/sipo_deserializer.sv
// Parametrised serial-in/parallel-out deserializer with word framing,
// selectable bit order and a registered valid/ready word port with overrun flag.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  input  logic             word_ready,
  output logic [WIDTH-1:0] parallel_out,
  output logic             word_valid,
  output logic             overrun,
  output logic [WIDTH-1:0] shift_out,
  output logic [CW-1:0]    bit_count
);

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_next;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] seeded;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             last_bit;
  logic             word_done;
  logic             handoff;

  // seeded is the register as if it had been empty before this bit arrived
  always_comb begin
    if (MSB_FIRST) begin
      shifted = {sh[WIDTH-2:0], serial_in};
      seeded  = {{(WIDTH-1){1'b0}}, serial_in};
    end else begin
      shifted = {serial_in, sh[WIDTH-1:1]};
      seeded  = {serial_in, {(WIDTH-1){1'b0}}};
    end
  end

  assign last_bit  = (count == CW'(WIDTH - 1));
  assign word_done = bit_valid && !frame_start && last_bit;
  assign handoff   = word_valid && word_ready;

  // frame_start realigns framing and never completes a word
  always_comb begin
    sh_next    = sh;
    count_next = count;
    if (frame_start) begin
      if (bit_valid) begin
        sh_next    = seeded;
        count_next = CW'(1);
      end else begin
        sh_next    = '0;
        count_next = '0;
      end
    end else if (bit_valid) begin
      sh_next    = shifted;
      count_next = last_bit ? '0 : count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh           <= '0;
      count        <= '0;
      parallel_out <= '0;
      word_valid   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sh      <= sh_next;
      count   <= count_next;
      overrun <= word_done && word_valid && !word_ready;
      if (word_done) begin
        parallel_out <= shifted;
        word_valid   <= 1'b1;
      end else if (handoff) begin
        word_valid <= 1'b0;
      end
    end
  end

  assign shift_out = sh;
  assign bit_count = count;

endmodule
